// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } ifetch_state_e;

  localparam int PC_STEP    = 4;
  localparam int FIFO_DEPTH = 2;

  // True when the two low PC bits describe a word boundary.
  function automatic logic word_aligned(input logic [1:0] lo);
    return (lo == 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry FIFO of fetched {PC, IR(, adel)} entries; head is a register so
// downstream sees only flopped values. clear drops everything synchronously.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry0_r, entry1_r, entry0_nxt_s, entry1_nxt_s;
  logic [1:0]       count_r, count_nxt_s;
  logic             valid_r, do_push_s, do_pop_s;

  // Next-state of the two slots; slot 0 is always the head.
  always_comb begin
    do_push_s    = push && ((count_r < 2'(FIFO_DEPTH)) || pop);
    do_pop_s     = pop && (count_r != 2'd0);
    entry0_nxt_s = entry0_r;
    entry1_nxt_s = entry1_r;
    count_nxt_s  = count_r;
    case ({do_push_s, do_pop_s})
      2'b10: begin
        if (count_r == 2'd0) begin
          entry0_nxt_s = push_data;
        end else begin
          entry1_nxt_s = push_data;
        end
        count_nxt_s = count_r + 2'd1;
      end
      2'b01: begin
        entry0_nxt_s = entry1_r;
        count_nxt_s  = count_r - 2'd1;
      end
      2'b11: begin
        if (count_r == 2'd1) begin
          entry0_nxt_s = push_data;
        end else begin
          entry0_nxt_s = entry1_r;
          entry1_nxt_s = push_data;
        end
      end
      default: count_nxt_s = count_r;
    endcase
  end

  // Slot, count and head-valid registers.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      entry0_r <= {WIDTH{1'b0}};
      entry1_r <= {WIDTH{1'b0}};
      count_r  <= 2'd0;
      valid_r  <= 1'b0;
    end else begin
      entry0_r <= entry0_nxt_s;
      entry1_r <= entry1_nxt_s;
      count_r  <= count_nxt_s;
      valid_r  <= (count_nxt_s != 2'd0);
    end
  end

  assign head_data  = entry0_r;
  assign head_valid = valid_r;
  assign count      = count_r;

endmodule

// File: rtl/instr_fetch.sv
// MIPS IF stage: PC register, single-outstanding imem fetch FSM and credit logic.
// Optional IFETCH_ALIGN_CHECK_EN adds adel_out and halts fetch on a misaligned PC.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int                 PC_BITS  = 32,
  parameter int                 IR_BITS  = 32,
  parameter logic [PC_BITS-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [PC_BITS-1:0] redirect_pc,
  output logic               imem_req,
  output logic [PC_BITS-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [IR_BITS-1:0] imem_rdata,
  input  logic               id_ready,
  output logic [PC_BITS-1:0] pc_out,
  output logic [IR_BITS-1:0] ir_out,
  output logic               valid_out
`ifdef IFETCH_ALIGN_CHECK_EN
  , output logic             adel_out
`endif
);

`ifdef IFETCH_ALIGN_CHECK_EN
  localparam int ENTRY_BITS = PC_BITS + IR_BITS + 1;
`else
  localparam int ENTRY_BITS = PC_BITS + IR_BITS;
`endif

  ifetch_state_e      state_r, state_nxt_s;
  logic [PC_BITS-1:0] fetch_pc_r, fetch_pc_nxt_s, issued_pc_r, issued_pc_nxt_s;
  logic [PC_BITS-1:0] imem_addr_r, push_pc_s;
  logic [IR_BITS-1:0] push_ir_s;
  logic               imem_req_r, req_nxt_s, halted_r, halted_nxt_s;
  logic               accept_s, pop_s, push_s, clear_s, aligned_nxt_s;
  logic [1:0]         count_s, count_nxt_s;
  logic [ENTRY_BITS-1:0] push_data_s, head_s;
  logic               head_valid_s;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic               push_adel_s;
`endif

  // FSM next state, PC update, FIFO push/clear and the credit check for the next request.
  always_comb begin
    state_nxt_s     = state_r;
    fetch_pc_nxt_s  = fetch_pc_r;
    issued_pc_nxt_s = issued_pc_r;
    halted_nxt_s    = halted_r;
    push_s          = 1'b0;
    push_pc_s       = issued_pc_r;
    push_ir_s       = imem_rdata;
    clear_s         = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    push_adel_s     = 1'b0;
`endif
    accept_s = imem_req_r & imem_ready;
    pop_s    = head_valid_s & id_ready;
    if (redirect) begin
      clear_s        = 1'b1;
      fetch_pc_nxt_s = redirect_pc;
      halted_nxt_s   = 1'b0;
      // An accepted or still-pending request must have its response swallowed.
      case (state_r)
        REQ:        state_nxt_s = accept_s ? DROP : REQ;
        WAIT, DROP: state_nxt_s = imem_rvalid ? REQ : DROP;
        default:    state_nxt_s = REQ;
      endcase
    end else begin
      case (state_r)
        IDLE: state_nxt_s = REQ;
        REQ: begin
          if (accept_s) begin
            issued_pc_nxt_s = fetch_pc_r;
            fetch_pc_nxt_s  = fetch_pc_r + PC_BITS'(PC_STEP);
            state_nxt_s     = WAIT;
          end
`ifdef IFETCH_ALIGN_CHECK_EN
          else if (!halted_r && !word_aligned(fetch_pc_r[1:0]) &&
                   (count_s < 2'(FIFO_DEPTH))) begin
            push_s       = 1'b1;
            push_pc_s    = fetch_pc_r;
            push_ir_s    = {IR_BITS{1'b0}};
            push_adel_s  = 1'b1;
            halted_nxt_s = 1'b1;
          end
`endif
          else begin
            state_nxt_s = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            push_s      = 1'b1;
            state_nxt_s = REQ;
          end else begin
            state_nxt_s = WAIT;
          end
        end
        DROP: state_nxt_s = imem_rvalid ? REQ : DROP;
        default: state_nxt_s = IDLE;
      endcase
    end
`ifdef IFETCH_ALIGN_CHECK_EN
    aligned_nxt_s = word_aligned(fetch_pc_nxt_s[1:0]);
    push_data_s   = {push_pc_s, push_ir_s, push_adel_s};
`else
    fetch_pc_nxt_s[1:0] = 2'b00;
    aligned_nxt_s       = 1'b1;
    push_data_s         = {push_pc_s, push_ir_s};
`endif
    count_nxt_s = clear_s ? 2'd0 : (count_s + {1'b0, push_s} - {1'b0, pop_s});
    req_nxt_s   = (state_nxt_s == REQ) && (count_nxt_s < 2'(FIFO_DEPTH)) &&
                  !halted_nxt_s && aligned_nxt_s;
  end

  // State, PC and registered memory-request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      fetch_pc_r  <= RESET_PC;
      issued_pc_r <= {PC_BITS{1'b0}};
      halted_r    <= 1'b0;
      imem_req_r  <= 1'b0;
      imem_addr_r <= RESET_PC;
    end else begin
      state_r     <= state_nxt_s;
      fetch_pc_r  <= fetch_pc_nxt_s;
      issued_pc_r <= issued_pc_nxt_s;
      halted_r    <= halted_nxt_s;
      imem_req_r  <= req_nxt_s;
      imem_addr_r <= fetch_pc_nxt_s;
    end
  end

  ifetch_fifo #(.WIDTH(ENTRY_BITS)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_s),
    .push       (push_s),
    .pop        (pop_s),
    .push_data  (push_data_s),
    .head_data  (head_s),
    .head_valid (head_valid_s),
    .count      (count_s)
  );

  assign imem_req  = imem_req_r;
  assign imem_addr = imem_addr_r;
  assign valid_out = head_valid_s;
  assign pc_out    = head_s[ENTRY_BITS-1 -: PC_BITS];
  assign ir_out    = head_s[ENTRY_BITS-PC_BITS-1 -: IR_BITS];
`ifdef IFETCH_ALIGN_CHECK_EN
  assign adel_out  = head_s[0];
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a small imem responder.
module tb_instr_fetch;

  logic        clk, rst, redirect, imem_req, imem_ready, imem_rvalid, id_ready, valid_out;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, pc_out, ir_out;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        adel_out;
`endif

  int errors = 0;
  int checks = 0;
  int mem_lat = 1;
  int lat_cnt = 0;
  int acc_count = 0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] acc_a;
  logic        acc;

  instr_fetch dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_ready(id_ready),
    .pc_out(pc_out), .ir_out(ir_out), .valid_out(valid_out)
`ifdef IFETCH_ALIGN_CHECK_EN
    , .adel_out(adel_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // imem responder: rvalid mem_lat cycles after acceptance, one at a time
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      acc   = imem_req && imem_ready;
      acc_a = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (acc) begin
        pend_addr = acc_a;
        last_addr = acc_a;
        lat_cnt   = mem_lat;
        acc_count++;
      end
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word_of(pend_addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; id_ready = 1'b1; mem_lat = 1;
    repeat (6) tick();
    acc_count = 0;
  endtask

  task automatic wait_acc(input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 30 && !ok; t++) begin
      if (acc_count >= n) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 30 && !ok; t++) begin
      if (valid_out === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    if (ir_out !== 32'h0) begin errors++; $display("FAIL reset_ir got=%h exp=0", ir_out); end
`ifdef IFETCH_ALIGN_CHECK_EN
    checks++;
    if (adel_out !== 1'b0) begin errors++; $display("FAIL reset_adel got=%b exp=0", adel_out); end
`endif
  endtask

  task automatic test_stream();
    logic [31:0] got_pc[3], got_ir[3];
    int n = 0;
    int first_t = 0;
    do_reset();
    rst = 1'b0;
    for (int t = 1; t <= 40 && n < 3; t++) begin
      tick();
      if (valid_out === 1'b1) begin
        if (n == 0) first_t = t;
        got_pc[n] = pc_out;
        got_ir[n] = ir_out;
        n++;
      end
    end
    checks += 2;
    if (n != 3) begin errors++; $display("FAIL stream_count got=%0d exp=3", n); end
    if (first_t != 3) begin errors++; $display("FAIL stream_latency got=%0d exp=3", first_t); end
    for (int i = 0; i < n; i++) begin
      checks += 2;
      if (got_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc%0d got=%h exp=%h", i, got_pc[i], 32'(4 * i)); end
      if (got_ir[i] !== word_of(32'(4 * i))) begin errors++; $display("FAIL stream_ir%0d got=%h exp=%h", i, got_ir[i], word_of(32'(4 * i))); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    id_ready = 1'b0;
    rst = 1'b0;
    repeat (12) tick();
    checks += 4;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req got=%b exp=0", imem_req); end
    if (acc_count != 2) begin errors++; $display("FAIL bp_fetches got=%0d exp=2", acc_count); end
    if (valid_out !== 1'b1 || pc_out !== 32'h0) begin errors++; $display("FAIL bp_head0 got=%b/%h exp=1/0", valid_out, pc_out); end
    if (ir_out !== word_of(32'h0)) begin errors++; $display("FAIL bp_ir0 got=%h exp=%h", ir_out, word_of(32'h0)); end
    id_ready = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h4) begin errors++; $display("FAIL bp_head1 got=%b/%h exp=1/4", valid_out, pc_out); end
    wait_acc(3, ok);
    checks++;
    if (!ok || last_addr !== 32'h8) begin errors++; $display("FAIL bp_resume got=%h exp=8", last_addr); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset();
    mem_lat = 3;
    rst = 1'b0;
    wait_acc(1, ok);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0; mem_lat = 1;
    checks++;
    if (!ok || valid_out !== 1'b0) begin errors++; $display("FAIL rw_valid got=%b exp=0", valid_out); end
    wait_valid(ok);
    checks += 2;
    if (!ok || pc_out !== 32'h100) begin errors++; $display("FAIL rw_first_pc got=%h exp=100", pc_out); end
    if (ir_out !== word_of(32'h100)) begin errors++; $display("FAIL rw_first_ir got=%h exp=%h", ir_out, word_of(32'h100)); end
  endtask

  task automatic test_redirect_rvalid();
    bit ok;
    do_reset();
    rst = 1'b0;
    wait_acc(1, ok);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    checks += 2;
    if (!ok || valid_out !== 1'b0) begin errors++; $display("FAIL rr_valid got=%b exp=0", valid_out); end
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rr_addr got=%b/%h exp=1/200", imem_req, imem_addr); end
    wait_valid(ok);
    checks++;
    if (!ok || pc_out !== 32'h200) begin errors++; $display("FAIL rr_first_pc got=%h exp=200", pc_out); end
  endtask

  task automatic test_stall_wrap();
    bit ok;
    do_reset();
    imem_ready = 1'b0;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stall_hold%0d got=%b/%h exp=1/0", i, imem_req, imem_addr); end
    end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; imem_ready = 1'b1;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redir got=%h exp=fffffffc", imem_addr); end
    wait_acc(2, ok);
    checks++;
    if (!ok || last_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%h exp=0", last_addr); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int seen = 0;
    do_reset();
    rst = 1'b0;
    wait_acc(2, ok);
    mem_lat = 4;
    wait_acc(3, ok);
    rst = 1'b1; imem_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (valid_out !== 1'b0) seen++;
    end
    checks++;
    if (!ok || seen != 0) begin errors++; $display("FAIL midrst_late got=%0d exp=0", seen); end
    mem_lat = 1; imem_ready = 1'b1;
    wait_valid(ok);
    checks++;
    if (!ok || pc_out !== 32'h0 || ir_out !== word_of(32'h0)) begin errors++; $display("FAIL midrst_first got=%h/%h exp=0/%h", pc_out, ir_out, word_of(32'h0)); end
  endtask

  task automatic test_align();
    bit ok;
    int reqs = 0;
    do_reset();
    rst = 1'b0;
    wait_acc(1, ok);
`ifdef IFETCH_ALIGN_CHECK_EN
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    wait_valid(ok);
    checks += 2;
    if (!ok || pc_out !== 32'h102 || ir_out !== 32'h0) begin errors++; $display("FAIL adel_entry got=%h/%h exp=102/0", pc_out, ir_out); end
    if (adel_out !== 1'b1) begin errors++; $display("FAIL adel_flag got=%b exp=1", adel_out); end
    for (int t = 0; t < 10; t++) begin
      tick();
      if (imem_req !== 1'b0) reqs++;
    end
    checks++;
    if (reqs != 0) begin errors++; $display("FAIL adel_halt got=%0d exp=0", reqs); end
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL adel_resume got=%b/%h exp=1/300", imem_req, imem_addr); end
    wait_valid(ok);
    checks++;
    if (!ok || pc_out !== 32'h300 || adel_out !== 1'b0) begin errors++; $display("FAIL adel_clean got=%h/%b exp=300/0", pc_out, adel_out); end
`else
    redirect = 1'b1; redirect_pc = 32'h106;
    tick();
    redirect = 1'b0;
    checks++;
    if (!ok || imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL lowbits got=%b/%h exp=1/104", imem_req, imem_addr); end
    wait_valid(ok);
    checks++;
    if (!ok || pc_out !== 32'h104 || ir_out !== word_of(32'h104)) begin errors++; $display("FAIL lowbits_entry got=%h/%h exp=104/%h", pc_out, ir_out, word_of(32'h104)); end
`endif
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; id_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_stall_wrap();
    test_mid_reset();
    test_align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
